// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating direction counters.
// Latency: lookup and mispredict are combinational; EX-stage training is visible the cycle after the update edge.
// Backpressure: none; every update strobe is taken on the rising edge it is presented at (no ready signal).
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_if,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Weakly taken: MSB set, remaining bits clear.
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t tbl [ENTRIES];

  // Fetch-side lookup fields.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  entry_t           lk_ent;
  logic             lk_hit;

  // Resolve-side fields.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  entry_t           up_ent;
  logic             up_hit;
  logic             up_br;
  logic [31:0]      actual_next;

  // The IF-stage direction bit travels with the instruction for debug only;
  // comparing full next-PCs already covers a wrong direction.
  logic unused_ok;
  assign unused_ok = &{1'b0, upd_pred_taken};

  assign lk_idx = pc_if[IDX_W+1:2];
  assign lk_tag = pc_if[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  // Combinational IF lookup; reads the pre-update entry during an update cycle.
  always_comb begin
    lk_ent      = tbl[lk_idx];
    lk_hit      = lk_ent.valid && (lk_ent.tag == lk_tag);
    pred_taken  = lk_hit && lk_ent.cnt[CNT_W-1];
    pred_target = pred_taken ? lk_ent.target : pc_if + 32'd4;
  end

  // Resolve the EX-stage instruction and flag a wrong next-PC for flush.
  always_comb begin
    up_ent      = tbl[up_idx];
    up_hit      = up_ent.valid && (up_ent.tag == up_tag);
    up_br       = upd_valid && upd_is_branch;
    actual_next = upd_taken ? upd_target : upd_pc + 32'd4;
    mispredict  = up_br && (actual_next != upd_pred_target);
  end

  // Train the table: hits move the counter, taken misses allocate over any resident entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '0;
      end
    end else if (up_br) begin
      if (up_hit) begin
        if (upd_taken) begin
          tbl[up_idx].target <= upd_target;
          if (up_ent.cnt != CNT_MAX) begin
            tbl[up_idx].cnt <= up_ent.cnt + CNT_ONE;
          end
        end else if (up_ent.cnt != '0) begin
          tbl[up_idx].cnt <= up_ent.cnt - CNT_ONE;
        end
      end else if (upd_taken) begin
        tbl[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, cnt: CNT_WEAK};
      end
    end
  end

  // Saturating performance counters for resolved branches and mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (up_br && (stat_branches != '1)) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (mispredict && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=64, CNT_W=2, STAT_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
// Covers reset, allocation, hysteresis, aliasing, non-branch, async reset, stat saturation.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [3:0]  stat_branches;
  logic [3:0]  stat_mispredicts;

  int tests = 0;
  int fails = 0;

  branch_predictor #(.ENTRIES(64), .CNT_W(2), .STAT_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_if           (pc_if),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_branch   (upd_is_branch),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic br, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_branch   = br;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_target = ptgt;
    upd_pred_taken  = (ptgt != pc + 32'd4);
  endtask

  task automatic idle();
    upd_valid     = 1'b0;
    upd_is_branch = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_tk, input logic [31:0] exp_tgt);
    pc_if = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    chk({tag, "_target"}, pred_target, exp_tgt);
  endtask

  task automatic stats(input string tag, input logic [3:0] b, input logic [3:0] m);
    chk({tag, "_branches"}, {28'd0, stat_branches}, {28'd0, b});
    chk({tag, "_mispredicts"}, {28'd0, stat_mispredicts}, {28'd0, m});
  endtask

  initial begin
    rst_n = 1'b0;
    pc_if = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;

    // Reset state
    #2;
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target, 32'h44);
    stats("rst", 4'd0, 4'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // First taken update at 0x100 allocates; lookup in same cycle sees old state
    upd(32'h100, 1'b1, 1'b1, 32'h80, 32'h104);
    #1;
    chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    look("alloc_same_cycle", 32'h100, 1'b0, 32'h104);
    tick();
    idle();
    look("alloc_next", 32'h100, 1'b1, 32'h80);
    stats("alloc", 4'd1, 4'd1);

    // Four correctly predicted taken updates: counter 2 -> 3 (saturated)
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 1'b1, 1'b1, 32'h80, 32'h80);
      tick();
    end
    idle();
    #1;
    chk("sat_no_mispredict", {31'd0, mispredict}, 32'd0);
    stats("sat", 4'd5, 4'd1);

    // First not-taken: 3 -> 2, still taken
    upd(32'h100, 1'b1, 1'b0, 32'h80, 32'h80);
    #1;
    chk("nt1_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    idle();
    look("nt1", 32'h100, 1'b1, 32'h80);

    // Second not-taken: 2 -> 1, predicts fall-through
    upd(32'h100, 1'b1, 1'b0, 32'h80, 32'h80);
    tick();
    idle();
    look("nt2", 32'h100, 1'b0, 32'h104);
    stats("nt2", 4'd7, 4'd3);

    // Aliasing: 0x200 shares index 0 with 0x100, different tag
    upd(32'h200, 1'b1, 1'b1, 32'h400, 32'h204);
    tick();
    idle();
    look("alias_new", 32'h200, 1'b1, 32'h400);
    look("alias_evicted", 32'h100, 1'b0, 32'h104);
    stats("alias", 4'd8, 4'd4);

    // Not-taken miss: no mispredict, no allocation, branch counted
    upd(32'h300, 1'b1, 1'b0, 32'h900, 32'h304);
    #1;
    chk("ntmiss_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    idle();
    look("ntmiss_lookup", 32'h300, 1'b0, 32'h304);
    look("ntmiss_keeps_resident", 32'h200, 1'b1, 32'h400);
    stats("ntmiss", 4'd9, 4'd4);

    // Non-branch: never mispredicts, never changes state
    upd(32'h500, 1'b0, 1'b1, 32'h40, 32'h504);
    #1;
    chk("nonbr_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    idle();
    look("nonbr_lookup", 32'h500, 1'b0, 32'h504);
    stats("nonbr", 4'd9, 4'd4);

    // Async reset asserted between edges while an update is presented
    upd(32'h200, 1'b1, 1'b1, 32'h400, 32'h204);
    #3 rst_n = 1'b0;
    #1;
    look("arst_lookup", 32'h200, 1'b0, 32'h204);
    stats("arst", 4'd0, 4'd0);
    chk("arst_mispredict_comb", {31'd0, mispredict}, 32'd1);
    tick();
    look("arst_ignored", 32'h200, 1'b0, 32'h204);
    stats("arst_ignored", 4'd0, 4'd0);
    #3 rst_n = 1'b1;
    tick();
    idle();
    look("post_rst_accept", 32'h200, 1'b1, 32'h400);
    stats("post_rst", 4'd1, 4'd1);

    // Stat saturation: 13 more mispredicts reach 14, then 7 more pin at 15
    for (int i = 0; i < 13; i++) begin
      upd(32'h1000, 1'b1, 1'b1, 32'h2000, 32'h1004);
      tick();
    end
    idle();
    #1;
    stats("pre_sat", 4'd14, 4'd14);
    for (int i = 0; i < 7; i++) begin
      upd(32'h1000, 1'b1, 1'b1, 32'h2000, 32'h1004);
      tick();
    end
    idle();
    #1;
    stats("stat_sat", 4'd15, 4'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
